// File: rtl/skrol_pozicija.sv
// Scroll index generator for the 4-digit text display: steps pozicija through
// 0..duzina_teksta-1 at a selectable rate, with direction, wrap and a toggled pause.
module skrol_pozicija #(
    parameter int unsigned PRESCALE   = 25_000_000,
    parameter int unsigned PRESCALE_W = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       smer,
    input  logic       pauza_btn,
    input  logic [1:0] brzina,
    input  logic [7:0] duzina_teksta,
    output logic [7:0] pozicija,
    output logic       korak,
    output logic       pauzirano
);

    logic                  btn_s1, btn_s2, btn_d;
    logic                  pauza_edge;
    logic [PRESCALE_W-1:0] cnt;
    logic [31:0]           period;
    logic [31:0]           cnt_ext;
    logic                  terminal;
    logic                  running;
    logic                  out_of_range;
    logic [8:0]            poz_inc;
    logic [7:0]            poz_next;

    assign pauza_edge   = btn_s2 & ~btn_d;
    assign running      = en & ~pauzirano;
    assign out_of_range = (pozicija >= duzina_teksta);
    assign period       = PRESCALE >> brzina;
    assign cnt_ext      = 32'(cnt);
    // ">=" rather than "==" so shortening the period mid-count ends it at once.
    assign terminal     = (cnt_ext >= period - 32'd1);
    // 9-bit increment keeps the wrap compare exact at duzina_teksta = 255.
    assign poz_inc      = {1'b0, pozicija} + 9'd1;

    always_comb begin
        poz_next = pozicija;
        if (!smer)
            poz_next = (poz_inc == {1'b0, duzina_teksta}) ? 8'd0 : poz_inc[7:0];
        else
            poz_next = (pozicija == 8'd0) ? duzina_teksta - 8'd1 : pozicija - 8'd1;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, e.g. a pause edge coincident with a terminal
    // count still lets that step happen.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_d     <= 1'b0;
            pauzirano <= 1'b0;
            cnt       <= '0;
            pozicija  <= 8'd0;
            korak     <= 1'b0;
        end else begin
            btn_s1 <= pauza_btn;
            btn_s2 <= btn_s1;
            btn_d  <= btn_s2;
            korak  <= 1'b0;
            if (pauza_edge)
                pauzirano <= ~pauzirano;

            // Empty text or a length that shrank below the index: park at 0.
            if (out_of_range) begin
                pozicija <= 8'd0;
                cnt      <= '0;
            end else if (running) begin
                if (terminal) begin
                    cnt      <= '0;
                    korak    <= 1'b1;
                    pozicija <= poz_next;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
